mdu_scheduler: RTL and testbench



---
 rtl/mdu_scheduler_if.sv | 32 +++
 rtl/mdu_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_mdu_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_scheduler_if
// Description : E-stage / D-stage bundle between the pipeline and the
//               multiply/divide scheduler (operands, op code, stall, HI/LO).
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_scheduler_if;
  logic [3:0]  E_MDOp;
  logic [31:0] E_RS;
  logic [31:0] E_RT;
  logic        D_IsMD;
  logic        E_Start;
  logic        E_Busy;
  logic        MD_Stall;
  logic [31:0] E_MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  // Pipeline side: issues operations, consumes stall and read data
  modport master (
    output E_MDOp, E_RS, E_RT, D_IsMD,
    input  E_Start, E_Busy, MD_Stall, E_MDOut, HI, LO
  );

  // Scheduler side
  modport slave (
    input  E_MDOp, E_RS, E_RT, D_IsMD,
    output E_Start, E_Busy, MD_Stall, E_MDOut, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mdu_scheduler
// Description : Owns HI/LO, models multiply/divide latency with a busy
//               counter, stalls MD-class instructions in D while the unit is
//               started or busy, and supplies mfhi/mflo read data to E.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_scheduler_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        phi_q, phi_d;   // pending HI
  logic [31:0]        plo_q, plo_d;   // pending LO
  logic               pwr_q, pwr_d;   // pending result is to be committed

  logic               start;
  logic               rt_zero;
  logic signed [63:0] rs_sx;
  logic signed [63:0] rt_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [63:0] quot_s;
  logic signed [63:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  // Start decode and the combinational outputs seen by E and D
  always_comb begin
    start       = (md.E_MDOp >= OP_MULT) && (md.E_MDOp <= OP_DIVU);
    md.E_Start  = start;
    md.E_Busy   = busy_q;
    md.MD_Stall = md.D_IsMD & (start | busy_q);
    md.HI       = hi_q;
    md.LO       = lo_q;
    if (md.E_MDOp == OP_MFHI) begin
      md.E_MDOut = hi_q;
    end else if (md.E_MDOp == OP_MFLO) begin
      md.E_MDOut = lo_q;
    end else begin
      md.E_MDOut = 32'd0;
    end
  end

  // Arithmetic results; signed divide runs at 64 bits so 0x80000000 / -1
  // yields +2^31, whose low word is the architecturally required 0x80000000
  always_comb begin
    rt_zero = (md.E_RT == 32'd0);
    rs_sx   = {{32{md.E_RS[31]}}, md.E_RS};
    rt_sx   = {{32{md.E_RT[31]}}, md.E_RT};
    prod_s  = rs_sx * rt_sx;
    prod_u  = {32'd0, md.E_RS} * {32'd0, md.E_RT};
    quot_s  = 64'sd0;
    rem_s   = 64'sd0;
    quot_u  = 32'd0;
    rem_u   = 32'd0;
    if (!rt_zero) begin
      quot_s = rs_sx / rt_sx;
      rem_s  = rs_sx % rt_sx;
      quot_u = md.E_RS / md.E_RT;
      rem_u  = md.E_RS % md.E_RT;
    end
  end

  // Next-state: start latches the pending result, busy counts down to commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          busy_d  = 1'b1;
          case (md.E_MDOp)
            OP_MULT: begin
              phi_d = prod_s[63:32];
              plo_d = prod_s[31:0];
              pwr_d = 1'b1;
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
              phi_d = prod_u[63:32];
              plo_d = prod_u[31:0];
              pwr_d = 1'b1;
              cnt_d = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
              phi_d = rem_s[31:0];
              plo_d = quot_s[31:0];
              pwr_d = !rt_zero;
              cnt_d = CNT_W'(DIV_CYCLES);
            end
            default: begin
              phi_d = rem_u;
              plo_d = quot_u;
              pwr_d = !rt_zero;
              cnt_d = CNT_W'(DIV_CYCLES);
            end
          endcase
        end else if (md.E_MDOp == OP_MTHI) begin
          hi_d = md.E_RS;
        end else if (md.E_MDOp == OP_MTLO) begin
          lo_d = md.E_RS;
        end
      end
      ST_BUSY: begin
        // Any MD op arriving here violates the stall protocol and is dropped
        if (cnt_q == CNT_W'(1)) begin
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
          pwr_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; reset abandons any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_scheduler
// Description : Directed and randomized bench for mdu_scheduler against a
//               cycle-level behavioural model of HI/LO and busy latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_scheduler_if md_if();

  mdu_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pok;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge given the inputs that were applied
  task automatic model_edge(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic rst);
    longint      sa, sb, q, r;
    logic [63:0] p;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else begin
      sa = longint'($signed(rs));
      sb = longint'($signed(rt));
      case (op)
        4'd1: begin
          p = 64'(sa * sb);
          m_phi = p[63:32]; m_plo = p[31:0]; m_pok = 1; m_left = MC;
        end
        4'd2: begin
          p = {32'd0, rs} * {32'd0, rt};
          m_phi = p[63:32]; m_plo = p[31:0]; m_pok = 1; m_left = MC;
        end
        4'd3: begin
          m_pok = (rt != 0); m_left = DC;
          if (rt != 0) begin
            q = sa / sb; r = sa % sb;
            m_plo = q[31:0]; m_phi = r[31:0];
          end
        end
        4'd4: begin
          m_pok = (rt != 0); m_left = DC;
          if (rt != 0) begin
            m_plo = rs / rt; m_phi = rs % rt;
          end
        end
        4'd5: m_hi = rs;
        4'd6: m_lo = rs;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, compare all outputs to the model, then clock
  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic dis, input logic rst);
    logic e_start, e_busy;
    logic [31:0] e_out;
    @(negedge clk);
    reset = rst; md_if.E_MDOp = op; md_if.E_RS = rs; md_if.E_RT = rt; md_if.D_IsMD = dis;
    #1;
    e_start = (op >= 4'd1 && op <= 4'd4);
    e_busy  = (m_left > 0);
    e_out   = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    chk("E_Start",  {31'd0, md_if.E_Start},  {31'd0, e_start});
    chk("E_Busy",   {31'd0, md_if.E_Busy},   {31'd0, e_busy});
    chk("MD_Stall", {31'd0, md_if.MD_Stall}, {31'd0, dis & (e_start | e_busy)});
    chk("E_MDOut",  md_if.E_MDOut, e_out);
    chk("HI",       md_if.HI, m_hi);
    chk("LO",       md_if.LO, m_lo);
    @(posedge clk);
    model_edge(op, rs, rt, rst);
  endtask

  task automatic idle(input int n, input logic dis);
    for (int i = 0; i < n; i++) step(4'd0, 32'd0, 32'd0, dis, 1'b0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    md_if.E_MDOp = 4'd0; md_if.E_RS = 32'd0; md_if.E_RT = 32'd0; md_if.D_IsMD = 1'b0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
    repeat (2) @(posedge clk);

    // Reset state
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // mult -2 * 3
    step(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    idle(MC, 1'b0);
    #2;
    chk("plan_mult_hi", md_if.HI, 32'hFFFF_FFFF);
    chk("plan_mult_lo", md_if.LO, 32'hFFFF_FFFA);
    chk("plan_mult_busy", {31'd0, md_if.E_Busy}, 32'd0);

    // multu max * max
    step(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(MC, 1'b0);
    #2;
    chk("plan_multu_hi", md_if.HI, 32'hFFFF_FFFE);
    chk("plan_multu_lo", md_if.LO, 32'h0000_0001);

    // div -7 / 2 with an MD instruction waiting in D
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    idle(DC, 1'b1);
    step(4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("plan_div_lo", md_if.LO, 32'hFFFF_FFFD);
    chk("plan_div_hi", md_if.HI, 32'hFFFF_FFFF);

    // divu by zero leaves HI/LO untouched
    step(4'd5, 32'h11, 32'd0, 1'b0, 1'b0);
    step(4'd6, 32'h22, 32'd0, 1'b0, 1'b0);
    step(4'd4, 32'd100, 32'd0, 1'b0, 1'b0);
    idle(DC + 1, 1'b0);
    #2;
    chk("plan_div0_hi", md_if.HI, 32'h11);
    chk("plan_div0_lo", md_if.LO, 32'h22);

    // mthi then mfhi
    step(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    step(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("plan_mthi", md_if.HI, 32'hDEAD_BEEF);

    // signed overflow case
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DC, 1'b0);
    #2;
    chk("plan_ovf_lo", md_if.LO, 32'h8000_0000);
    chk("plan_ovf_hi", md_if.HI, 32'h0);

    // reset during the fourth busy cycle abandons the divide
    step(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #2;
    chk("plan_rst_busy", {31'd0, md_if.E_Busy}, 32'd0);
    idle(DC + 2, 1'b0);
    #2;
    chk("plan_rst_hi", md_if.HI, 32'd0);
    chk("plan_rst_lo", md_if.LO, 32'd0);

    // Randomized traffic, including protocol-violating ops during busy
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(op, rnd_val(), ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
